fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100: redirect address on trap; present only with FETCH_TRAP_EN.
REQ-003 SHALL have port clk  in  1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port stall  in  1: decode cannot accept the presented instruction.
REQ-006 SHALL have ports br_taken  in  1 and br_target  in  32: branch/jump redirect request and target.
REQ-007 SHALL have port trap_req  in  1: trap redirect request; present only with FETCH_TRAP_EN.
REQ-008 SHALL have ports imem_req  out  1, imem_addr  out  32, imem_ack  in  1, imem_rdata  in  32: instruction-memory handshake.
REQ-009 SHALL have ports inst_valid  out  1, inst  out  32, inst_pc  out  32: fetched instruction to decode.
REQ-010 SHALL have port pc  out  32: current fetch PC; imem_addr equals pc.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, HOLD, KILL.
REQ-012 SHALL go IDLE->REQ unconditionally one cycle after reset release.
REQ-013 SHALL assert imem_req in REQ and KILL; imem_addr stable until imem_ack.
REQ-014 SHALL, on imem_ack in REQ without redirect: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1 next cycle (1-cycle latency), pc<=pc+4.
REQ-015 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-016 SHALL, with inst_valid=1 and stall=1, enter HOLD: inst/inst_pc/inst_valid frozen, imem_req=0.
REQ-017 SHALL leave HOLD for REQ on the first cycle stall=0; the held instruction is consumed that cycle.
REQ-018 SHALL clear inst_valid in the cycle after an instruction is consumed unless a new ack arrives that cycle (back-to-back).
REQ-019 SHALL prioritise redirects: trap_req > br_taken > sequential.
REQ-020 SHALL force redirect target bits [1:0] to 0.
REQ-021 SHALL, on redirect in REQ with imem_ack same cycle: discard imem_rdata, pc<=target, inst_valid<=0, stay REQ.
REQ-022 SHALL, on redirect in REQ without ack: pc<=target, go KILL; in KILL imem_req stays 1 with the old address latched until ack, then data discarded, go REQ at target.
REQ-023 SHALL, on redirect in KILL: replace pending target; latest redirect wins.
REQ-024 SHALL, on redirect in HOLD: inst_valid<=0, pc<=target, go REQ, ignoring stall.
REQ-025 SHALL never present an instruction fetched from a killed address.

Reset
REQ-026 SHALL on rst: pc=RESET_PC, state=IDLE, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-027 SHALL abandon any outstanding fetch on rst mid-transaction; an imem_ack in the first cycle after release is ignored.

Configuration
REQ-028 SHALL, with FETCH_TRAP_EN defined, include trap_req and TRAP_VEC; trap_req redirects to TRAP_VEC with highest priority.
REQ-029 SHALL, without FETCH_TRAP_EN, omit trap_req and TRAP_VEC; only br_taken redirects.

Verification
REQ-030 SHALL cover reset, ack every cycle -> imem_addr 0,4,8,...; inst_pc 0,4,8 on consecutive cycles.
REQ-031 SHALL cover stall=1 for 3 cycles at inst_pc=8 -> inst_valid held, inst stable, imem_req=0; stall release -> fetch of 12 issues.
REQ-032 SHALL cover br_taken target 32'h0000_0043 with ack delayed 2 cycles -> old fetch discarded, next inst_pc=32'h0000_0040.
REQ-033 SHALL cover trap_req and br_taken same cycle (FETCH_TRAP_EN) -> pc=32'h0000_0100.
REQ-034 SHALL cover RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-035 SHALL cover rst asserted while imem_req=1 -> outputs at reset values immediately; after release first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC fetch with stall hold and branch redirect.
// Optional trap redirect to TRAP_VEC is built when FETCH_TRAP_EN is defined.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
`ifdef FETCH_TRAP_EN
   input  logic        trap_req,
`endif
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] pc
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] KILL = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] kill_addr_q, kill_addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;

   logic        redirect;
   logic [31:0] target_raw;
   logic [31:0] target;
   logic        ack;

   always_comb begin
`ifdef FETCH_TRAP_EN
      redirect   = trap_req | br_taken;
      target_raw = trap_req ? TRAP_VEC : br_target;
`else
      redirect   = br_taken;
      target_raw = br_target;
`endif
      target = target_raw & ~32'h0000_0003;
   end

   // The request is withdrawn while a presented instruction is stalled, so no
   // second instruction can arrive with nowhere to go.
   always_comb begin
      imem_req  = (state_q == KILL) || ((state_q == REQ) && !(inst_valid_q && stall));
      imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;
      ack       = imem_req && imem_ack;
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_addr_d  = kill_addr_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (redirect) begin
               pc_d         = target;
               inst_valid_d = 1'b0;
               // An unanswered request must be drained before fetching the target.
               if (imem_req && !ack) begin
                  kill_addr_d = pc_q;
                  state_d     = KILL;
               end
            end else if (ack) begin
               inst_d       = imem_rdata;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
            end else if (inst_valid_q && stall) begin
               state_d = HOLD;
            end else begin
               inst_valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d         = target;
               inst_valid_d = 1'b0;
               state_d      = REQ;
            end else if (!stall) begin
               inst_valid_d = 1'b0;
               state_d      = REQ;
            end
         end
         KILL: begin
            inst_valid_d = 1'b0;
            if (redirect) begin
               pc_d = target;
            end
            if (ack) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         kill_addr_q  <= 32'h0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_addr_q  <= kill_addr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stall hold, redirects, PC wrap, reset.
module tb_fetch_ctrl;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
`ifdef FETCH_TRAP_EN
   logic        trap_req;
`endif
   logic        imem_ack;

   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        inst_valid, inst_valid2;
   logic [31:0] inst, inst2;
   logic [31:0] inst_pc, inst_pc2;
   logic [31:0] pc, pc2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory model: data word is the address xor a fixed pattern.
   assign imem_rdata  = imem_addr ^ K;
   assign imem_rdata2 = imem_addr2 ^ K;

   fetch_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
`ifdef FETCH_TRAP_EN
      .trap_req   (trap_req),
`endif
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .pc         (pc)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
`ifdef FETCH_TRAP_EN
      .trap_req   (trap_req),
`endif
      .imem_req   (imem_req2),
      .imem_addr  (imem_addr2),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata2),
      .inst_valid (inst_valid2),
      .inst       (inst2),
      .inst_pc    (inst_pc2),
      .pc         (pc2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; imem_ack = 1'b0;
`ifdef FETCH_TRAP_EN
      trap_req = 1'b0;
`endif
      #2;
      chk("rst_req",    {31'b0, imem_req},   32'h0);
      chk("rst_valid",  {31'b0, inst_valid}, 32'h0);
      chk("rst_inst",   inst,    32'h0);
      chk("rst_instpc", inst_pc, 32'h0);
      chk("rst_pc",     pc,      32'h0);
      chk("rst_pc2",    pc2,     32'hFFFF_FFFC);

      // Release with ack already high: the IDLE cycle must ignore it.
      tick(); rst = 1'b0; imem_ack = 1'b1; #1;
      chk("idle_req", {31'b0, imem_req}, 32'h0);
      tick();
      chk("e1_req",   {31'b0, imem_req},   32'h1);
      chk("e1_addr",  imem_addr, 32'h0);
      chk("e1_valid", {31'b0, inst_valid}, 32'h0);
      chk("e1_addr2", imem_addr2, 32'hFFFF_FFFC);
      tick();
      chk("e2_valid",  {31'b0, inst_valid}, 32'h1);
      chk("e2_instpc", inst_pc, 32'h0);
      chk("e2_inst",   inst,    32'h0 ^ K);
      chk("e2_addr",   imem_addr,  32'h4);
      chk("e2_addr2",  imem_addr2, 32'h0);
      chk("e2_instpc2", inst_pc2, 32'hFFFF_FFFC);
      tick();
      chk("e3_instpc", inst_pc, 32'h4);
      chk("e3_addr",   imem_addr, 32'h8);
      tick();
      chk("e4_instpc", inst_pc, 32'h8);
      chk("e4_inst",   inst, 32'h8 ^ K);

      // Stall three cycles on inst_pc=8.
      stall = 1'b1; #1;
      chk("st0_req", {31'b0, imem_req}, 32'h0);
      tick();
      chk("st1_valid", {31'b0, inst_valid}, 32'h1);
      chk("st1_instpc", inst_pc, 32'h8);
      chk("st1_inst", inst, 32'h8 ^ K);
      chk("st1_req", {31'b0, imem_req}, 32'h0);
      tick();
      chk("st2_valid", {31'b0, inst_valid}, 32'h1);
      chk("st2_instpc", inst_pc, 32'h8);
      chk("st2_req", {31'b0, imem_req}, 32'h0);
      tick(); stall = 1'b0; #1;
      chk("st3_valid", {31'b0, inst_valid}, 32'h1);
      chk("st3_req", {31'b0, imem_req}, 32'h0);
      tick();
      chk("rel_valid", {31'b0, inst_valid}, 32'h0);
      chk("rel_req",   {31'b0, imem_req},   32'h1);
      chk("rel_addr",  imem_addr, 32'hC);
      tick();
      chk("f12_instpc", inst_pc, 32'hC);
      chk("f12_valid", {31'b0, inst_valid}, 32'h1);

      // Branch with the outstanding ack delayed two cycles.
      imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0043; #1;
      tick(); br_taken = 1'b0; #1;
      chk("k0_req",   {31'b0, imem_req}, 32'h1);
      chk("k0_addr",  imem_addr, 32'h10);
      chk("k0_pc",    pc, 32'h40);
      chk("k0_valid", {31'b0, inst_valid}, 32'h0);
      tick();
      chk("k1_addr",  imem_addr, 32'h10);
      chk("k1_valid", {31'b0, inst_valid}, 32'h0);
      imem_ack = 1'b1;
      tick();
      chk("k2_valid", {31'b0, inst_valid}, 32'h0);
      chk("k2_addr",  imem_addr, 32'h40);
      chk("k2_req",   {31'b0, imem_req}, 32'h1);
      tick();
      chk("br_valid",  {31'b0, inst_valid}, 32'h1);
      chk("br_instpc", inst_pc, 32'h40);
      chk("br_inst",   inst, 32'h40 ^ K);

      // Branch coincident with ack: data dropped, no KILL.
      br_taken = 1'b1; br_target = 32'h0000_0200;
      tick(); br_taken = 1'b0; #1;
      chk("ra_valid", {31'b0, inst_valid}, 32'h0);
      chk("ra_pc",    pc, 32'h200);
      chk("ra_addr",  imem_addr, 32'h200);
      tick();
      chk("ra_instpc", inst_pc, 32'h200);
      stall = 1'b1; #1;
      chk("h0_req", {31'b0, imem_req}, 32'h0);

      // Branch while holding overrides stall.
      tick(); br_taken = 1'b1; br_target = 32'h0000_0305; #1;
      tick(); br_taken = 1'b0; stall = 1'b0; #1;
      chk("hb_valid", {31'b0, inst_valid}, 32'h0);
      chk("hb_pc",    pc, 32'h304);
      chk("hb_req",   {31'b0, imem_req}, 32'h1);
      tick();
      chk("hb_instpc", inst_pc, 32'h304);

      // Two redirects while draining: the later target wins.
      imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0500;
      tick(); br_target = 32'h0000_0600; #1;
      chk("kk0_addr", imem_addr, 32'h308);
      chk("kk0_pc",   pc, 32'h500);
      tick(); br_taken = 1'b0; imem_ack = 1'b1; #1;
      chk("kk1_addr",  imem_addr, 32'h308);
      chk("kk1_pc",    pc, 32'h600);
      chk("kk1_valid", {31'b0, inst_valid}, 32'h0);
      tick();
      chk("kk2_addr",  imem_addr, 32'h600);
      chk("kk2_valid", {31'b0, inst_valid}, 32'h0);
      tick();
      chk("kk3_instpc", inst_pc, 32'h600);
      chk("kk3_valid", {31'b0, inst_valid}, 32'h1);

`ifdef FETCH_TRAP_EN
      trap_req = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0700;
      tick(); trap_req = 1'b0; br_taken = 1'b0; #1;
      chk("trap_pc",    pc, 32'h100);
      chk("trap_valid", {31'b0, inst_valid}, 32'h0);
      tick();
      chk("trap_instpc", inst_pc, 32'h100);
      chk("trap_valid2", {31'b0, inst_valid}, 32'h1);
`endif

      // Reset in the middle of an outstanding request.
      imem_ack = 1'b0; #1;
      chk("mr_req_pre", {31'b0, imem_req}, 32'h1);
      rst = 1'b1; #1;
      chk("mr_req",    {31'b0, imem_req},   32'h0);
      chk("mr_valid",  {31'b0, inst_valid}, 32'h0);
      chk("mr_inst",   inst,    32'h0);
      chk("mr_instpc", inst_pc, 32'h0);
      chk("mr_pc",     pc,      32'h0);
      tick(); rst = 1'b0; imem_ack = 1'b1; #1;
      chk("mr_idle_req", {31'b0, imem_req}, 32'h0);
      tick();
      chk("mr_addr",  imem_addr, 32'h0);
      chk("mr_req2",  {31'b0, imem_req}, 32'h1);
      chk("mr_valid2", {31'b0, inst_valid}, 32'h0);
      tick();
      chk("mr_instpc2", inst_pc, 32'h0);
      chk("mr_valid3", {31'b0, inst_valid}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
